// File: rtl/ascii_stream_generator.sv
// ascii_stream_generator: on an execute rising edge, produces gen_len printable
// ASCII characters (incrementing or LFSR-derived) into a show-ahead FIFO that
// a GPIO-attached processor drains with a valid/read handshake.
module ascii_stream_generator #(
  parameter int          COUNT_W   = 12,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               execute,
  input  logic               mode,
  input  logic [COUNT_W-1:0] gen_len,
  input  logic               rd_en,
  output logic [7:0]         generated_ascii,
  output logic               valid,
  output logic [COUNT_W-1:0] generate_count,
  output logic               busy,
  output logic               done
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_OCC = (AW+1)'(DEPTH);
  localparam logic [7:0]    CHR_LO   = 8'h20;
  localparam logic [7:0]    CHR_HI   = 8'h7E;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               execute_q;
  logic [COUNT_W-1:0] len_q, len_d;
  logic               mode_q, mode_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]         chr_q, chr_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [7:0]         mem_q [DEPTH];

  logic               start, push, pop, full;
  logic [AW:0]        occ;
  logic [COUNT_W-1:0] cnt_inc;
  logic [6:0]         lfsr_v;
  logic [7:0]         lfsr_chr, push_chr;
  logic               lfsr_fb;

  // FIFO status, handshake and character selection
  always_comb begin
    occ      = wr_ptr_q - rd_ptr_q;
    full     = (occ == FULL_OCC);
    valid    = (occ != '0);
    start    = execute & ~execute_q & (state_q != RUN);
    push     = (state_q == RUN) & ~full;
    pop      = rd_en & valid;
    cnt_inc  = cnt_q + 1'b1;
    lfsr_v   = lfsr_q[6:0];
    // 7-bit value folded into the 95-character printable range
    lfsr_chr = (lfsr_v < 7'd95) ? CHR_LO + {1'b0, lfsr_v}
                                : CHR_LO + {1'b0, lfsr_v - 7'd95};
    push_chr = mode_q ? lfsr_chr : chr_q;
    lfsr_fb  = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = (gen_len == '0) ? DONE : RUN;
      RUN:        if (push && cnt_inc == len_q) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Run parameters, generator state and FIFO pointers
  always_comb begin
    len_d    = len_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    chr_d    = chr_q;
    lfsr_d   = lfsr_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    if (start) begin
      len_d  = gen_len;
      mode_d = mode;
      cnt_d  = '0;
      chr_d  = CHR_LO;
      lfsr_d = LFSR_SEED;
    end else if (push) begin
      cnt_d = cnt_inc;
      if (mode_q) lfsr_d = {lfsr_q[14:0], lfsr_fb};
      else        chr_d  = (chr_q == CHR_HI) ? CHR_LO : chr_q + 8'd1;
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      execute_q <= 1'b0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      chr_q     <= CHR_LO;
      lfsr_q    <= LFSR_SEED;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      execute_q <= execute;
      len_q     <= len_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      chr_q     <= chr_d;
      lfsr_q    <= lfsr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_chr;
  end

  assign generated_ascii = valid ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
  assign generate_count  = cnt_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);

endmodule

// File: tb/tb_ascii_stream_generator.sv
// tb_ascii_stream_generator: scenario tasks checking the generator against a
// behavioural character-sequence model.
module tb_ascii_stream_generator;
  localparam int          COUNT_W = 12;
  localparam int          DEPTH   = 16;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic               clk = 1'b0;
  logic               reset, execute, mode, rd_en;
  logic [COUNT_W-1:0] gen_len;
  logic [7:0]         generated_ascii;
  logic               valid, busy, done;
  logic [COUNT_W-1:0] generate_count;

  int pass_cnt = 0;
  int total    = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] first_run[$];

  ascii_stream_generator #(.COUNT_W(COUNT_W), .DEPTH(DEPTH), .LFSR_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .execute(execute), .mode(mode), .gen_len(gen_len),
    .rd_en(rd_en), .generated_ascii(generated_ascii), .valid(valid),
    .generate_count(generate_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference: the n characters a run of the given mode must produce
  task automatic build_exp(input logic m, input int n);
    logic [15:0] l;
    int v;
    exp_q = {};
    l = SEED;
    for (int i = 0; i < n; i++) begin
      if (!m) exp_q.push_back(8'(32 + (i % 95)));
      else begin
        v = l % 128;
        exp_q.push_back(8'((v < 95) ? 32 + v : 32 + v - 95));
        l = {l[14:0], ^(l & 16'hB400)};
      end
    end
  endtask

  // Raise execute after a low cycle so the next edge is sampled as a start
  task automatic kick(input logic m, input int n);
    execute = 1'b0;
    tick();
    mode    = m;
    gen_len = COUNT_W'(n);
    execute = 1'b1;
    tick();
  endtask

  // Pop until the run is done and the FIFO empty, collecting heads into got
  task automatic drain(input int budget, input bit rnd, output bit to);
    int n = 0;
    got = {};
    while (!(done && !valid) && n < budget) begin
      rd_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (valid && rd_en) got.push_back(generated_ascii);
      tick();
      n++;
    end
    rd_en = 1'b0;
    to = (n >= budget);
  endtask

  task automatic cmp_seq(input string name);
    total++;
    if (got.size() !== exp_q.size())
      $display("FAIL %s length: got %0d want %0d", name, got.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      total++;
      if (got[i] !== exp_q[i])
        $display("FAIL %s char[%0d]: got %02h want %02h", name, i, got[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; execute = 1'b0; mode = 1'b0; gen_len = '0; rd_en = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      rd_en = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({valid, busy, done, generated_ascii, generate_count} !== '0)
        $display("FAIL reset_idle cyc%0d: v=%b b=%b d=%b a=%02h c=%0d want all 0",
                 i, valid, busy, done, generated_ascii, generate_count);
      else pass_cnt++;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_inc5();
    rd_en = 1'b1;
    kick(1'b0, 5);
    total++;
    if (busy !== 1'b1 || generate_count !== 0)
      $display("FAIL inc5_start: busy=%b cnt=%0d want 1/0", busy, generate_count);
    else pass_cnt++;
    got = {};
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (valid) got.push_back(generated_ascii);
      if (i == 1) begin
        total++;
        if (generate_count !== 1 || valid !== 1'b1)
          $display("FAIL inc5_first_push: cnt=%0d valid=%b want 1/1", generate_count, valid);
        else pass_cnt++;
      end
      if (i == 4) begin
        total++;
        if (done !== 1'b0) $display("FAIL inc5_done_early: done=%b want 0", done);
        else pass_cnt++;
      end
      if (i == 5) begin
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || generate_count !== 5)
          $display("FAIL inc5_done: done=%b busy=%b cnt=%0d want 1/0/5", done, busy, generate_count);
        else pass_cnt++;
      end
    end
    rd_en = 1'b0;
    build_exp(1'b0, 5);
    cmp_seq("inc5");
  endtask

  task automatic test_backpressure();
    bit to;
    rd_en = 1'b0;
    kick(1'b0, 100);
    repeat (30) tick();
    total++;
    if (generate_count !== 16 || busy !== 1'b1 || valid !== 1'b1 || generated_ascii !== 8'h20)
      $display("FAIL stall: cnt=%0d busy=%b valid=%b head=%02h want 16/1/1/20",
               generate_count, busy, valid, generated_ascii);
    else pass_cnt++;
    drain(400, 1'b0, to);
    total++;
    if (to || done !== 1'b1 || generate_count !== 100)
      $display("FAIL stall_end: timeout=%b done=%b cnt=%0d want 0/1/100", to, done, generate_count);
    else pass_cnt++;
    build_exp(1'b0, 100);
    cmp_seq("inc100");
  endtask

  task automatic test_lfsr();
    bit to;
    kick(1'b1, 3);
    drain(100, 1'b0, to);
    total++;
    if (to || got.size() < 1 || got[0] !== 8'h22)
      $display("FAIL lfsr_first: timeout=%b n=%0d first=%02h want 22", to, got.size(),
               (got.size() > 0) ? got[0] : 8'hxx);
    else pass_cnt++;
    build_exp(1'b1, 3);
    cmp_seq("lfsr3");
    first_run = got;
    kick(1'b1, 3);
    drain(100, 1'b0, to);
    exp_q = first_run;
    cmp_seq("lfsr3_rerun");
  endtask

  task automatic test_zero_and_ignore();
    int n = 0;
    kick(1'b0, 0);
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0 || generate_count !== 0)
      $display("FAIL zero_len: done=%b busy=%b valid=%b cnt=%0d want 1/0/0/0",
               done, busy, valid, generate_count);
    else pass_cnt++;
    repeat (3) tick();
    total++;
    if (valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_len_hold: valid=%b busy=%b want 0/0", valid, busy);
    else pass_cnt++;
    kick(1'b0, 50);
    rd_en = 1'b1;
    got = {};
    while (!(done && !valid) && n < 300) begin
      if (n == 10) execute = 1'b0;
      if (n == 12) execute = 1'b1;
      if (valid) got.push_back(generated_ascii);
      tick();
      n++;
    end
    rd_en = 1'b0;
    total++;
    if (n >= 300 || generate_count !== 50)
      $display("FAIL ignore_edge: cycles=%0d cnt=%0d want <300/50", n, generate_count);
    else pass_cnt++;
    build_exp(1'b0, 50);
    cmp_seq("ignore50");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit to;
    rd_en = 1'b0;
    kick(1'b0, 100);
    while (generate_count !== 7 && n < 50) begin tick(); n++; end
    total++;
    if (generate_count !== 7) $display("FAIL mid_reach7: cnt=%0d want 7", generate_count);
    else pass_cnt++;
    reset = 1'b1; execute = 1'b0;
    tick();
    total++;
    if ({valid, busy, done, generated_ascii, generate_count} !== '0)
      $display("FAIL mid_reset: v=%b b=%b d=%b a=%02h c=%0d want all 0",
               valid, busy, done, generated_ascii, generate_count);
    else pass_cnt++;
    reset = 1'b0;
    kick(1'b0, 3);
    drain(100, 1'b0, to);
    build_exp(1'b0, 3);
    cmp_seq("after_reset");
  endtask

  task automatic test_random();
    bit to;
    logic m;
    int len;
    for (int r = 0; r < 4; r++) begin
      m   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      kick(m, len);
      drain(2000, 1'b1, to);
      total++;
      if (to || generate_count !== COUNT_W'(len))
        $display("FAIL rand%0d_end: timeout=%b cnt=%0d want %0d", r, to, generate_count, len);
      else pass_cnt++;
      build_exp(m, len);
      cmp_seq($sformatf("rand%0d", r));
    end
  endtask

  initial begin
    test_reset();
    test_inc5();
    test_backpressure();
    test_lfsr();
    test_zero_and_ignore();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
